// File: rtl/regfile_dump_unit_pkg.sv
// Shared types and widths for the register-file dump unit and its neighbours
// (register file, CPU datapath).
package regfile_dump_unit_pkg;

   localparam int unsigned REG_ADDR_W = 4;
   localparam int unsigned REG_DATA_W = 16;
   localparam int unsigned BYTE_W     = 8;

   localparam logic [BYTE_W-1:0] HDR_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      FETCH,
      SEND_HI,
      SEND_LO,
      CSUM,
      DONE
   } state_e;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Byte stream with valid/ready handshake carried from the dump unit to its sink.
interface regfile_dump_unit_if;
   import regfile_dump_unit_pkg::*;

   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump_unit.sv
// Walks a register range through a spare read port and streams it as
// header, big-endian register bytes, and an XOR checksum.
module regfile_dump_unit
   import regfile_dump_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = REG_ADDR_W,
   parameter int unsigned       DATA_W   = REG_DATA_W,
   parameter logic [BYTE_W-1:0] HDR_BYTE = HDR_BYTE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    first_addr,
   input  logic [ADDR_W-1:0]    last_addr,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]    rd_data,
   regfile_dump_unit_if.master  tx,
   output logic                 busy,
   output logic                 done
);

   state_e             state_q,    state_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0]  last_q,     last_d;
   logic [DATA_W-1:0]  shadow_q,   shadow_d;
   logic [BYTE_W-1:0]  csum_q,     csum_d;
   logic [BYTE_W-1:0]  tx_data_q,  tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic [ADDR_W-1:0]  rd_addr_q,  rd_addr_d;
   logic               hs;

   // Next state; outputs are derived from the next state so they leave flops.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      last_d     = last_q;
      shadow_d   = shadow_q;
      csum_d     = csum_q;
      tx_data_d  = tx_data_q;
      hs         = tx_valid_q && tx.tx_ready;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               cur_addr_d = first_addr;
               last_d     = last_addr;
               csum_d     = '0;
               tx_data_d  = HDR_BYTE;
               state_d    = HDR;
            end
         end
         HDR: begin
            if (hs) begin
               csum_d  = csum_q ^ tx_data_q;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // Snapshot taken at this edge; a same-edge write is not seen.
            shadow_d  = rd_data;
            tx_data_d = rd_data[DATA_W-1 -: BYTE_W];
            state_d   = SEND_HI;
         end
         SEND_HI: begin
            tx_data_d = shadow_q[DATA_W-1 -: BYTE_W];
            if (hs) begin
               csum_d    = csum_q ^ tx_data_q;
               tx_data_d = shadow_q[BYTE_W-1:0];
               state_d   = SEND_LO;
            end
         end
         SEND_LO: begin
            if (hs) begin
               csum_d = csum_q ^ tx_data_q;
               if (cur_addr_q == last_q) begin
                  tx_data_d = csum_q ^ tx_data_q;
                  state_d   = CSUM;
               end else begin
                  cur_addr_d = cur_addr_q + ADDR_W'(1);
                  state_d    = FETCH;
               end
            end
         end
         CSUM: begin
            if (hs) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_valid_d = (state_d == HDR) || (state_d == SEND_HI) ||
                   (state_d == SEND_LO) || (state_d == CSUM);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      rd_addr_d  = cur_addr_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         last_q     <= '0;
         shadow_q   <= '0;
         csum_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         last_q     <= last_d;
         shadow_q   <= shadow_d;
         csum_q     <= csum_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: register-file model, frame reference model,
// stream scoreboard, directed scenarios and randomized dumps.
module tb_regfile_dump_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  first_addr, last_addr, rd_addr;
   logic [15:0] rd_data;
   logic        busy, done;

   regfile_dump_unit_if txif ();

   regfile_dump_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .tx         (txif),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on rising edge.
   logic [15:0] regs [16];
   logic [15:0] load_vals [16];
   logic        load_en, we;
   logic [3:0]  wa;
   logic [15:0] wd;
   assign rd_data = regs[rd_addr];
   always @(posedge clk) begin
      if (load_en) regs <= load_vals;
      else if (we) regs[wa] <= wd;
   end

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int rdy_mode = 0;
   int cyc = 0;

   function automatic void chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference frame: header, each register high/low byte in range order, XOR of all.
   function automatic int build_frame(input logic [3:0] f, input logic [3:0] l);
      logic [7:0] x;
      logic [3:0] r;
      int n;
      n = int'(4'(l - f)) + 1;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      x = 8'hA5;
      for (int i = 0; i < n; i++) begin
         r = 4'(f + 4'(i));
         exp_q.push_back(regs[r][15:8]);
         exp_q.push_back(regs[r][7:0]);
         x = x ^ regs[r][15:8] ^ regs[r][7:0];
      end
      exp_q.push_back(x);
      return n;
   endfunction

   // Sink readiness: always, random, or 2-on/2-off with a 3-cycle stall.
   initial begin
      txif.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         case (rdy_mode)
            0: txif.tx_ready = 1'b1;
            1: txif.tx_ready = ($urandom_range(0, 2) != 0);
            default: txif.tx_ready = ((cyc % 10) inside {0, 1, 4, 5, 9});
         endcase
      end
   end

   // Scoreboard: byte order, stall stability, done pulse and return to idle.
   bit         prev_stall = 0, pend_done = 0, pend_idle = 0;
   logic [7:0] prev_data  = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
         pend_done  = 0;
         pend_idle  = 0;
      end else begin
         if (prev_stall)
            chk(txif.tx_valid && txif.tx_data == prev_data, "stall_hold",
                int'(txif.tx_data), int'(prev_data));
         if (pend_done) begin
            chk(done && busy, "done_pulse", {done, busy}, 2'b11);
            pend_done = 0;
            pend_idle = 1;
         end else if (pend_idle) begin
            chk(!done && !busy && !txif.tx_valid, "idle_after_done",
                {done, busy, txif.tx_valid}, 0);
            pend_idle = 0;
         end else if (done) begin
            chk(1'b0, "spurious_done", 1, 0);
         end
         if (txif.tx_valid && txif.tx_ready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "extra_byte", int'(txif.tx_data), -1);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk(txif.tx_data == e, "stream_byte", int'(txif.tx_data), int'(e));
               got_q.push_back(txif.tx_data);
               if (exp_q.size() == 0) pend_done = 1;
            end
         end
         prev_stall = txif.tx_valid && !txif.tx_ready;
         prev_data  = txif.tx_data;
      end
   end

   task automatic load_regs();
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic check_got(input string name, input logic [7:0] lit [$]);
      chk(got_q.size() == lit.size(), {name, "_len"}, got_q.size(), lit.size());
      for (int i = 0; i < lit.size() && i < got_q.size(); i++)
         chk(got_q[i] == lit[i], name, int'(got_q[i]), int'(lit[i]));
   endtask

   // One dump; wr_mode 1 writes R5 in its FETCH cycle, 2 writes R5 after it.
   task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input bit lat,
                           input bit abuse, input int wr_mode, input logic [15:0] wval);
      int  cnt, n;
      bit  seen, wrote;
      cnt = build_frame(f, l);
      got_q.delete();
      @(negedge clk);
      start = 1'b1; first_addr = f; last_addr = l;
      @(negedge clk);
      start = 1'b0; first_addr = 4'($urandom); last_addr = 4'($urandom);
      chk(txif.tx_valid && busy && txif.tx_data == 8'hA5, "hdr_after_start",
          {txif.tx_valid, busy, txif.tx_data}, {2'b11, 8'hA5});
      n = 1; seen = 0; wrote = 0;
      while (!seen && n < 800) begin
         if (done) begin
            seen = 1;
         end else begin
            we = 1'b0;
            start = 1'b0;
            if (abuse && $urandom_range(0, 3) == 0) begin
               start = 1'b1;
               first_addr = 4'($urandom);
               last_addr  = 4'($urandom);
            end
            if (!wrote && rd_addr == 4'd5 && busy && !done &&
                ((wr_mode == 1 && !txif.tx_valid) || (wr_mode == 2 && txif.tx_valid))) begin
               we = 1'b1; wa = 4'd5; wd = wval; wrote = 1;
            end
            @(negedge clk);
            n++;
         end
      end
      we = 1'b0;
      start = abuse;
      chk(seen, "done_timeout", int'(seen), 1);
      if (lat) chk(n == 3 * cnt + 3, "latency", n, 3 * cnt + 3);
      if (wr_mode != 0) chk(wrote, "write_hook", int'(wrote), 1);
      @(negedge clk);
      start = 1'b0;
      chk(exp_q.size() == 0, "frame_complete", exp_q.size(), 0);
      chk(got_q.size() == 2 + 2 * cnt, "frame_len", got_q.size(), 2 + 2 * cnt);
   endtask

   initial begin
      logic [7:0] lit [$];
      rst = 1'b1; start = 1'b0; we = 1'b0; load_en = 1'b0; wa = '0; wd = '0;
      first_addr = '0; last_addr = '0;
      for (int i = 0; i < 16; i++) load_vals[i] = '0;
      #1;
      chk(!txif.tx_valid && !busy && !done && txif.tx_data == 8'h00 && rd_addr == 4'd0,
          "reset_state", {txif.tx_valid, busy, done, txif.tx_data, rd_addr}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic dump
      rdy_mode = 0;
      load_vals[0] = 16'h1234; load_vals[1] = 16'hABCD;
      load_regs();
      run_dump(4'd0, 4'd1, 1'b1, 1'b0, 0, '0);
      lit = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE5};
      check_got("basic_bytes", lit);

      // Single register
      load_vals[3] = 16'hBEEF;
      load_regs();
      run_dump(4'd3, 4'd3, 1'b1, 1'b0, 0, '0);
      lit = '{8'hA5, 8'hBE, 8'hEF, 8'hF4};
      check_got("single_bytes", lit);

      // Wrap 15 -> 0
      load_vals[15] = 16'h00FF;
      load_regs();
      run_dump(4'd15, 4'd0, 1'b1, 1'b0, 0, '0);
      lit = '{8'hA5, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h7C};
      check_got("wrap_bytes", lit);

      // Backpressure on the basic dump
      rdy_mode = 2;
      run_dump(4'd0, 4'd1, 1'b0, 1'b0, 0, '0);
      lit = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE5};
      check_got("bp_bytes", lit);

      // Full range with writes to R5 at and after its fetch
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) load_vals[i] = 16'(i * 16'h1111);
      load_regs();
      run_dump(4'd0, 4'd15, 1'b1, 1'b0, 1, 16'hDEAD);
      chk(got_q.size() > 11 && got_q[11] == 8'h55 && got_q[12] == 8'h55, "r5_fetch_write_old",
          got_q.size() > 12 ? {got_q[11], got_q[12]} : 0, 16'h5555);
      rdy_mode = 1;
      run_dump(4'd0, 4'd15, 1'b0, 1'b0, 2, 16'hBEEF);
      chk(got_q.size() > 12 && got_q[11] == 8'hDE && got_q[12] == 8'hAD, "r5_late_write",
          got_q.size() > 12 ? {got_q[11], got_q[12]} : 0, 16'hDEAD);

      // Reset during SEND_LO, then a fresh frame
      rdy_mode = 0;
      build_frame(4'd0, 4'd3);
      got_q.delete();
      @(negedge clk);
      start = 1'b1; first_addr = 4'd0; last_addr = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50 && got_q.size() < 2; k++) @(negedge clk);
      chk(got_q.size() == 2, "reach_send_lo", got_q.size(), 2);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk(!txif.tx_valid && !busy && !done, "async_reset",
          {txif.tx_valid, busy, done}, 0);
      exp_q.delete();
      got_q.delete();
      @(negedge clk);
      #1;
      chk(!txif.tx_valid && !busy, "reset_held", {txif.tx_valid, busy}, 0);
      rst = 1'b0;
      run_dump(4'd2, 4'd4, 1'b1, 1'b0, 0, '0);
      chk(got_q.size() > 0 && got_q[0] == 8'hA5, "fresh_header",
          got_q.size() > 0 ? int'(got_q[0]) : -1, 8'hA5);

      // Start abuse while busy and in DONE
      rdy_mode = 1;
      run_dump(4'd9, 4'd11, 1'b0, 1'b1, 0, '0);

      // Randomized dumps
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 16; i++) load_vals[i] = 16'($urandom);
         load_regs();
         rdy_mode = int'($urandom_range(0, 2));
         run_dump(4'($urandom), 4'($urandom), rdy_mode == 0, 1'($urandom), 0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Debug reader for the CPU's 16 x 16-bit register file: on a start pulse it walks a register address range through a spare combinational read port.
- It serialises each register onto a byte stream with a valid/ready handshake, e.g. toward a UART transmitter.
- The stream is framed by a header byte and a trailing XOR checksum.
- It sits beside the register file and only reads it; the CPU keeps running during a dump.

Parameters:
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width (fixed at 2 bytes per register)
- HDR_BYTE, 8'hA5, frame header byte

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled in IDLE only
- first_addr  in  ADDR_W  first register of range; latched on accepted start
- last_addr  in  ADDR_W  last register of range (inclusive); latched on accepted start
- rd_addr  out  ADDR_W  address to register file read port
- rd_data  in  DATA_W  combinational read data for rd_addr
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready at rising clk
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after checksum byte accepted

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset behaviour: state=IDLE, tx_valid=0, tx_data=0, rd_addr=0, busy=0, done=0, checksum=0. Takes effect immediately, including mid-dump. No partial frame continues after reset.
- IDLE:
  - start=1 latches first_addr/last_addr, loads cur_addr=first_addr, clears checksum, and goes to HDR.
  - start=0 stays in IDLE.
- HDR: tx_valid=1, tx_data=HDR_BYTE. On handshake: checksum^=byte, go to FETCH.
- FETCH (exactly one cycle):
  - rd_addr=cur_addr; tx_valid=0.
  - At the clock edge, capture rd_data into a 16-bit shadow register, then go to SEND_HI.
- SEND_HI: tx_data=shadow[15:8]. On handshake: checksum^=byte, go to SEND_LO.
- SEND_LO: tx_data=shadow[7:0]. On handshake: checksum^=byte, then:
  - if cur_addr==last_addr, go to CSUM;
  - else cur_addr=cur_addr+1 (mod 16), go to FETCH.
- CSUM: tx_data=checksum, the XOR of the header and all data bytes. On handshake go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. A new start is accepted on the following IDLE cycle.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and state are held stable.
  - tx_valid never deasserts without a handshake, except on reset.
  - tx_ready has no effect when tx_valid=0.
- Range:
  - count = ((last_addr - first_addr) mod 16) + 1.
  - first==last sends one register.
  - last<first wraps through 15 to 0. Example: first=14, last=1 gives 14,15,0,1.
  - first=0, last=15 sends all 16.
- Frame length is 2 + 2*count bytes.
- Minimum latency with tx_ready held high:
  - start to header valid: 1 cycle;
  - per register: 3 cycles (FETCH, HI, LO);
  - checksum, then done on the next cycle.
- Coherency:
  - Each register is snapshotted at its FETCH edge.
  - A write to that register in the same cycle returns the old value, because the register file writes on the same edge.
  - No atomicity across registers.
- start while busy is ignored, and start in DONE is ignored. first_addr/last_addr changes while busy are ignored.
- rd_addr holds cur_addr outside FETCH (don't-care for the register file).

Decomposition:
- Shared package holds:
  - the state enum IDLE/HDR/FETCH/SEND_HI/SEND_LO/CSUM/DONE;
  - HDR_BYTE default;
  - REG_ADDR_W=4 and REG_DATA_W=16, shared with the register file and CPU datapath.
- No sub-module needed: FSM plus address counter, shadow and checksum registers in one module.

Test Plan:
- Basic dump: R0=0x1234, R1=0xABCD, first=0, last=1, tx_ready=1 -> bytes A5,12,34,AB,CD,E5. done pulses 1 cycle after E5 accepted; busy drops with it.
- Single register: R3=0xBEEF, first=last=3 -> A5,BE,EF,F4. Frame is 4 bytes.
- Wrap: R15=0x00FF, R0=0x1234, first=15, last=0 -> A5,00,FF,12,34,7C.
- Backpressure: basic dump with tx_ready toggling 0/1 every 2 cycles and 3-cycle stalls -> identical byte sequence. tx_data is stable for all cycles where valid && !ready. No duplicated or dropped bytes.
- Full range plus concurrent writes:
  - Dump 0..15 with Rn=n*0x1111 gives 34 bytes, in order, with correct checksum.
  - A write to R5 in the FETCH cycle of R5 yields the old value.
  - A write to R5 after its FETCH is not reflected.
- Reset/start abuse:
  - Assert rst during SEND_LO -> tx_valid=0 and busy=0 immediately, without waiting for a clock edge.
  - A subsequent start produces a fresh frame beginning A5.
  - start pulses while busy do not restart or lengthen the frame.
